// File: rtl/iir_biquad_seq_pkg.sv
// Shared types and constants for the biquad sequencer: float word width,
// sequencer states and coefficient slot indices.
package iir_pkg;
  localparam int DEF_MAN = 23;
  localparam int DEF_EXP = 8;
  localparam int FW = DEF_MAN + DEF_EXP + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL0,
    S_MAC1,
    S_MAC2,
    S_MAC3,
    S_MAC4,
    S_ACC_LAST,
    S_OUT
  } state_t;

  localparam logic [2:0] C_B0  = 3'd0;
  localparam logic [2:0] C_B1  = 3'd1;
  localparam logic [2:0] C_B2  = 3'd2;
  localparam logic [2:0] C_NA1 = 3'd3;
  localparam logic [2:0] C_NA2 = 3'd4;

  localparam logic [FW-1:0] FLOAT_ZERO = '0;
  localparam logic [FW-1:0] FLOAT_ONE  = {2'b00, {(DEF_EXP-1){1'b1}}, {DEF_MAN{1'b0}}};
endpackage

// File: rtl/iir_biquad_seq_if.sv
// Sample stream, result stream and coefficient-write port of the biquad sequencer.
interface iir_biquad_seq_if #(
  parameter int MAN = 23,
  parameter int EXP = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [MAN-1:0]       in_sample;
  logic                 out_valid;
  logic                 out_ready;
  logic [MAN+EXP:0]     out_sample;
  logic                 coef_we;
  logic [2:0]           coef_addr;
  logic [MAN+EXP:0]     coef_data;
  logic                 clr;
  logic                 busy;

  modport master (
    output in_valid, in_sample, out_ready, coef_we, coef_addr, coef_data, clr,
    input  in_ready, out_valid, out_sample, busy
  );

  modport slave (
    input  in_valid, in_sample, out_ready, coef_we, coef_addr, coef_data, clr,
    output in_ready, out_valid, out_sample, busy
  );
endinterface

// File: rtl/iir_biquad_seq_coef_bank.sv
// Shadow/active coefficient banks; the active bank is swapped in when a sample
// is accepted so a running computation never sees a half-updated set.
module iir_coef_bank
  import iir_pkg::*;
#(
  parameter int FWB = FW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [2:0]     addr,
  input  logic [FWB-1:0] wdata,
  input  logic           commit,
  input  state_t         state,
  output logic [FWB-1:0] coef
);
  logic [FWB-1:0] shadow [5];
  logic [FWB-1:0] active [5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (commit) active <= shadow;
      if (we) begin
        case (addr)
          C_B0:    shadow[0] <= wdata;
          C_B1:    shadow[1] <= wdata;
          C_B2:    shadow[2] <= wdata;
          C_NA1:   shadow[3] <= wdata;
          C_NA2:   shadow[4] <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    coef = '0;
    case (state)
      S_MUL0:  coef = active[C_B0];
      S_MAC1:  coef = active[C_B1];
      S_MAC2:  coef = active[C_B2];
      S_MAC3:  coef = active[C_NA1];
      S_MAC4:  coef = active[C_NA2];
      default: coef = '0;
    endcase
  end
endmodule

// File: rtl/iir_float_ops.sv
// Minimal float primitives for the biquad datapath: truncating, denormals
// flushed to zero, no inf/NaN encoding.
module int2float #(
  parameter int MAN = 23,
  parameter int EXP = 8
) (
  input  logic [MAN-1:0]   a,
  output logic [MAN+EXP:0] f
);
  localparam int BIAS = (1 << (EXP - 1)) - 1;
  logic [MAN-1:0] mag;
  logic [MAN:0]   norm;
  int             msb;

  always_comb begin
    mag = a[MAN-1] ? (~a + 1'b1) : a;
    msb = 0;
    for (int i = 0; i < MAN; i++)
      if (mag[i]) msb = i;
    norm = {1'b0, mag} << (MAN - msb);
    f = '0;
    if (mag != '0) f = {a[MAN-1], EXP'(BIAS + msb), norm[MAN-1:0]};
  end
endmodule

module mult #(
  parameter int MAN = 23,
  parameter int EXP = 8
) (
  input  logic [MAN+EXP:0] a,
  input  logic [MAN+EXP:0] b,
  output logic [MAN+EXP:0] p
);
  localparam logic signed [EXP+1:0] BIAS_S = (EXP+2)'((1 << (EXP - 1)) - 1);
  localparam logic signed [EXP+1:0] EMAX   = (EXP+2)'((1 << EXP) - 1);
  localparam logic signed [EXP+1:0] EONE   = (EXP+2)'(1);
  logic [2*MAN+1:0]     prod;
  logic [MAN-1:0]       man;
  logic signed [EXP+1:0] e;

  always_comb begin
    prod = {1'b1, a[MAN-1:0]} * {1'b1, b[MAN-1:0]};
    e = $signed({2'b00, a[MAN+EXP-1:MAN]}) + $signed({2'b00, b[MAN+EXP-1:MAN]}) - BIAS_S;
    man = prod[2*MAN+1] ? prod[2*MAN:MAN+1] : prod[2*MAN-1:MAN];
    if (prod[2*MAN+1]) e = e + EONE;
    p = '0;
    if (a[MAN+EXP-1:MAN] != '0 && b[MAN+EXP-1:MAN] != '0 && e > 0) begin
      if (e >= EMAX) p = {a[MAN+EXP] ^ b[MAN+EXP], {(EXP-1){1'b1}}, 1'b0, {MAN{1'b1}}};
      else           p = {a[MAN+EXP] ^ b[MAN+EXP], e[EXP-1:0], man};
    end
  end
endmodule

module soma #(
  parameter int MAN = 23,
  parameter int EXP = 8
) (
  input  logic [MAN+EXP:0] a,
  input  logic [MAN+EXP:0] b,
  output logic [MAN+EXP:0] s
);
  // hidden bit + mantissa + two guard bits below the LSB
  localparam int MW = MAN + 3;
  localparam logic [EXP-1:0] MW_E = EXP'(MW);
  localparam logic signed [EXP+1:0] EONE = (EXP+2)'(1);
  logic [MAN+EXP:0]      big, sml;
  logic [EXP-1:0]        eb, es, dsh;
  logic [MW-1:0]         mb, ms;
  logic [MW:0]           sum, norm;
  logic signed [EXP+1:0] e;
  int                    lead;

  always_comb begin
    if (a[MAN+EXP-1:0] >= b[MAN+EXP-1:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    eb  = big[MAN+EXP-1:MAN];
    es  = sml[MAN+EXP-1:MAN];
    mb  = {1'b1, big[MAN-1:0], 2'b00};
    ms  = (es == '0) ? '0 : {1'b1, sml[MAN-1:0], 2'b00};
    dsh = eb - es;
    ms  = (dsh >= MW_E) ? '0 : (ms >> dsh);
    sum = (big[MAN+EXP] == sml[MAN+EXP]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
    lead = 0;
    for (int i = 0; i <= MW; i++)
      if (sum[i]) lead = i;
    e = $signed({2'b00, eb});
    if (lead == MW) begin
      norm = sum >> 1;
      e = e + EONE;
    end else begin
      norm = sum << (MW - 1 - lead);
      e = e - $signed((EXP+2)'(MW - 1 - lead));
    end
    s = '0;
    if (eb != '0 && sum != '0 && e > 0) s = {big[MAN+EXP], e[EXP-1:0], norm[MW-2:2]};
  end
endmodule

module float2int #(
  parameter int MAN = 23,
  parameter int EXP = 8
) (
  input  logic [MAN+EXP:0] f,
  output logic [MAN+EXP:0] i
);
  localparam int W    = MAN + EXP + 1;
  localparam int BIAS = (1 << (EXP - 1)) - 1;
  logic [W-1:0] mag;
  int           sh;

  // Truncates toward zero; magnitudes beyond the word saturate.
  always_comb begin
    sh  = int'(f[MAN+EXP-1:MAN]) - BIAS;
    mag = '0;
    if (sh >= W - 1)    mag = {1'b0, {(W-1){1'b1}}};
    else if (sh >= MAN) mag = W'({1'b1, f[MAN-1:0]}) << (sh - MAN);
    else if (sh >= 0)   mag = W'({1'b1, f[MAN-1:0]}) >> (MAN - sh);
    i = f[MAN+EXP] ? (~mag + 1'b1) : mag;
  end
endmodule

// File: rtl/iir_biquad_seq.sv
// Direct-form-I biquad sequencer sharing one float multiplier and one adder
// across the five taps.
//   state    | meaning
//   IDLE     | waiting for a sample, in_ready high
//   MUL0     | prod = b0*x0
//   MAC1     | acc = prod, prod = b1*x1
//   MAC2..4  | acc += prod, prod = b2*x2 / na1*y1 / na2*y2
//   ACC_LAST | acc += prod, latch integer result
//   OUT      | hold result until out_ready, then shift delay line
module iir_biquad_seq
  import iir_pkg::*;
#(
  parameter int MAN = DEF_MAN,
  parameter int EXP = DEF_EXP
) (
  input logic               clk,
  input logic               rst_n,
  iir_biquad_seq_if.slave   bus
);
  localparam int W = MAN + EXP + 1;

  state_t         state, state_nxt;
  logic [W-1:0]   x0, x1, x2, y1, y2, prod, acc, out_q;
  logic [W-1:0]   x_flt, mul_res, sum_res, int_res, coef, operand;
  logic           in_ready, accept, ld_prod, acc_byp, acc_add, ld_out, shift;

  iir_coef_bank #(.FWB(W)) u_coef (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bus.coef_we),
    .addr   (bus.coef_addr),
    .wdata  (bus.coef_data),
    .commit (accept),
    .state  (state),
    .coef   (coef)
  );

  int2float #(.MAN(MAN), .EXP(EXP)) u_i2f (.a(bus.in_sample), .f(x_flt));
  mult      #(.MAN(MAN), .EXP(EXP)) u_mul (.a(coef), .b(operand), .p(mul_res));
  soma      #(.MAN(MAN), .EXP(EXP)) u_add (.a(acc), .b(prod), .s(sum_res));
  float2int #(.MAN(MAN), .EXP(EXP)) u_f2i (.f(sum_res), .i(int_res));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept) state_nxt = S_MUL0;
      S_MUL0:     state_nxt = S_MAC1;
      S_MAC1:     state_nxt = S_MAC2;
      S_MAC2:     state_nxt = S_MAC3;
      S_MAC3:     state_nxt = S_MAC4;
      S_MAC4:     state_nxt = S_ACC_LAST;
      S_ACC_LAST: state_nxt = S_OUT;
      S_OUT:      if (bus.out_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (bus.clr) state_nxt = S_IDLE;
  end

  always_comb begin
    in_ready = (state == S_IDLE) && !bus.clr;
    accept   = in_ready && bus.in_valid;
    ld_prod  = (state == S_MUL0) || (state == S_MAC1) || (state == S_MAC2) ||
               (state == S_MAC3) || (state == S_MAC4);
    acc_byp  = (state == S_MAC1);
    acc_add  = (state == S_MAC2) || (state == S_MAC3) || (state == S_MAC4) ||
               (state == S_ACC_LAST);
    ld_out   = (state == S_ACC_LAST);
    shift    = (state == S_OUT) && bus.out_ready;
    operand  = '0;
    case (state)
      S_MUL0:  operand = x0;
      S_MAC1:  operand = x1;
      S_MAC2:  operand = x2;
      S_MAC3:  operand = y1;
      S_MAC4:  operand = y2;
      default: operand = '0;
    endcase
  end

  assign bus.in_ready   = in_ready;
  assign bus.busy       = (state != S_IDLE);
  assign bus.out_valid  = (state == S_OUT);
  assign bus.out_sample = out_q;

  // y1/y2 keep the float accumulator so feedback is not quantised to integers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0 <= '0; x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
      prod <= '0; acc <= '0; out_q <= '0;
    end else if (bus.clr) begin
      x0 <= '0; x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
      prod <= '0; acc <= '0;
    end else begin
      if (accept)       x0 <= x_flt;
      if (ld_prod)      prod <= mul_res;
      if (acc_byp)      acc <= prod;
      else if (acc_add) acc <= sum_res;
      if (ld_out)       out_q <= int_res;
      if (shift) begin
        x2 <= x1;
        x1 <= x0;
        y2 <= y1;
        y1 <= acc;
      end
    end
  end
endmodule

// File: tb/tb_iir_biquad_seq.sv
// Directed and randomized checks of the biquad sequencer against a real-valued
// difference-equation model.
module tb_iir_biquad_seq;
  localparam int MAN = 23;
  localparam int EXP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iir_biquad_seq_if #(.MAN(MAN), .EXP(EXP)) ifc ();
  iir_biquad_seq #(.MAN(MAN), .EXP(EXP)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  int  n_checks = 0;
  int  n_fail = 0;
  real sh [5];
  real mx1, mx2, my1, my2;
  real bset [7] = '{0.0, 0.5, -0.5, 1.0, -1.0, 2.0, 1.5};
  real a1set [3] = '{0.0, 0.5, -0.5};
  real a2set [3] = '{0.0, 0.25, -0.25};

  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    logic [10:0] e11;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e11 = d[62:52];
    return {d[63], 8'(e11 - 11'd896), d[51:29]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic clear_history();
    mx1 = 0.0; mx2 = 0.0; my1 = 0.0; my2 = 0.0;
  endtask

  task automatic set_coef(input int a, input real v);
    ifc.coef_we = 1'b1;
    ifc.coef_addr = a[2:0];
    ifc.coef_data = to_f32(v);
    sh[a] = v;
    @(negedge clk);
    ifc.coef_we = 1'b0;
  endtask

  // clr together with in_valid: sample must be refused and history wiped
  task automatic flush();
    ifc.clr = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_sample = 23'd77;
    #1 check("in_ready_under_clr", ifc.in_ready, 0);
    @(negedge clk);
    ifc.clr = 1'b0;
    ifc.in_valid = 1'b0;
    check("busy_after_clr", ifc.busy, 0);
    clear_history();
  endtask

  // act: 0 = coefficient write, 1 = clr, 2 = rst_n pulse, issued at lat == act_at
  task automatic do_sample(input int x, input int stall, input int act_at, input int act,
                           input int waddr, input real wval);
    real y;
    logic [31:0] yexp;
    int lat;
    bit gone;
    check("in_ready_idle", ifc.in_ready, 1);
    ifc.in_valid = 1'b1;
    ifc.in_sample = MAN'(x);
    y = sh[0] * x + sh[1] * mx1 + sh[2] * mx2 + sh[3] * my1 + sh[4] * my2;
    yexp = $rtoi(y);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    check("in_ready_running", ifc.in_ready, 0);
    check("busy_running", ifc.busy, 1);
    lat = 0;
    gone = 1'b0;
    while (!ifc.out_valid && lat < 12) begin
      if (lat == act_at) begin
        if (act == 0) begin
          ifc.coef_we = 1'b1;
          ifc.coef_addr = waddr[2:0];
          ifc.coef_data = to_f32(wval);
          sh[waddr] = wval;
        end else if (act == 1) begin
          ifc.clr = 1'b1;
          gone = 1'b1;
          clear_history();
        end else begin
          rst_n = 1'b0;
          gone = 1'b1;
          #1;
          check("rst_out_sample", ifc.out_sample, 0);
          check("rst_out_valid", ifc.out_valid, 0);
          check("rst_busy", ifc.busy, 0);
          check("rst_in_ready", ifc.in_ready, 1);
          clear_history();
          for (int k = 0; k < 5; k++) sh[k] = 0.0;
        end
      end
      @(negedge clk);
      lat++;
      ifc.coef_we = 1'b0;
      ifc.clr = 1'b0;
      rst_n = 1'b1;
    end
    if (gone) begin
      check("no_output_after_abort", ifc.out_valid, 0);
      return;
    end
    check("latency", lat, 6);
    check("out_sample", ifc.out_sample, yexp);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("hold_out_valid", ifc.out_valid, 1);
      check("hold_out_sample", ifc.out_sample, yexp);
      check("hold_in_ready", ifc.in_ready, 0);
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    check("out_valid_drop", ifc.out_valid, 0);
    mx2 = mx1; mx1 = x; my2 = my1; my1 = y;
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_sample = '0;
    ifc.out_ready = 1'b0;
    ifc.coef_we = 1'b0;
    ifc.coef_addr = '0;
    ifc.coef_data = '0;
    ifc.clr = 1'b0;
    for (int k = 0; k < 5; k++) sh[k] = 0.0;
    clear_history();

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", ifc.in_ready, 1);
    check("reset_out_valid", ifc.out_valid, 0);
    check("reset_out_sample", ifc.out_sample, 0);
    check("reset_busy", ifc.busy, 0);

    // pass-through
    set_coef(0, 1.0);
    do_sample(5, 0, -1, 0, 0, 0.0);

    // FIR 1,2,1 impulse response
    flush();
    set_coef(1, 2.0);
    set_coef(2, 1.0);
    do_sample(1, 0, -1, 0, 0, 0.0);
    do_sample(0, 0, -1, 0, 0, 0.0);
    do_sample(0, 0, -1, 0, 0, 0.0);
    do_sample(0, 0, -1, 0, 0, 0.0);

    // one-pole decay
    flush();
    set_coef(1, 0.0);
    set_coef(2, 0.0);
    set_coef(3, 0.5);
    foreach (bset[k]) if (k < 4) do_sample((k == 0) ? 8 : 0, 0, -1, 0, 0, 0.0);

    // output back-pressure
    do_sample(6, 10, -1, 0, 0, 0.0);

    // coefficient write mid-computation lands on the next sample
    flush();
    set_coef(3, 0.0);
    set_coef(0, 1.0);
    do_sample(3, 0, 2, 0, 0, 2.0);
    do_sample(3, 0, -1, 0, 0, 0.0);

    // clr during MAC3 after nonzero history
    set_coef(0, 1.0);
    set_coef(3, 0.5);
    do_sample(10, 0, -1, 0, 0, 0.0);
    do_sample(7, 0, 3, 1, 0, 0.0);
    do_sample(4, 0, -1, 0, 0, 0.0);

    // async reset mid-computation, then zero coefficients
    do_sample(9, 0, 3, 2, 0, 0.0);
    do_sample(9, 0, -1, 0, 0, 0.0);

    // randomized coefficient sets and input streams
    for (int r = 0; r < 3; r++) begin
      flush();
      for (int c = 0; c < 3; c++) set_coef(c, bset[$urandom_range(0, 6)]);
      set_coef(3, a1set[$urandom_range(0, 2)]);
      set_coef(4, a2set[$urandom_range(0, 2)]);
      for (int n = 0; n < 6; n++)
        do_sample(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 3)), -1, 0, 0, 0.0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
